serial_deser4: RTL and testbench
================================

SERIAL_DESER4 -- requirements
Module: serial_deser4

Interface
REQ-001 The block SHALL have parameter PARITY_EN, default 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 means the first data bit lands in out[3]; 0 means it lands in out[0].
REQ-003 Port clk: input, 1 bit, sole clock, rising-edge.
REQ-004 Port res: input, 1 bit, reset; asynchronous, active-low.
REQ-005 Port sin: input, 1 bit, serial data line, sampled only when sin_en=1.
REQ-006 Port sin_en: input, 1 bit, bit-slot strobe; each rising edge with sin_en=1 is one bit slot.
REQ-007 Port out: output, 4 bits, assembled word; registered; feeds the downstream 4-bit parallel register.
REQ-008 Port out_valid: output, 1 bit, out holds a complete, parity-checked word.
REQ-009 Port out_ready: input, 1 bit, downstream accepts the word.
REQ-010 Port par_err: output, 1 bit, one-cycle pulse on parity mismatch.
REQ-011 Port overrun: output, 1 bit, sticky flag: a frame start arrived while a word was pending.
REQ-012 Port ovr_clr: input, 1 bit, synchronous clear of overrun.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, COLLECT, PARITY, HOLD.
REQ-014 IDLE: a bit slot with sin=1 is a start bit; the FSM SHALL move to COLLECT with bit counter=0; slots with sin=0 SHALL be ignored.
REQ-015 COLLECT: each bit slot SHALL shift sin into the internal shift register (MSB_FIRST: shift left, enter at bit 0; else shift right, enter at bit 3) and increment the counter.
REQ-016 When the 4th bit is taken, the FSM SHALL go to PARITY if PARITY_EN=1, else to HOLD.
REQ-017 PARITY: on a bit slot, even parity SHALL be checked over the 4 data bits plus sin.
REQ-018 On parity pass, the FSM SHALL load out and go to HOLD; on fail, it SHALL pulse par_err for 1 cycle, leave out unchanged, discard the frame and go to IDLE.
REQ-019 Latency: out and out_valid SHALL update on the same edge that samples the final bit (last data bit or parity bit); both are visible the following cycle.
REQ-020 HOLD: out_valid SHALL be 1 and out SHALL be stable; out_ready=1 SHALL complete the handshake, and on the next edge out_valid=0 and the FSM returns to IDLE.
REQ-021 out SHALL retain its last value after the handshake; out changes only on a successful frame.
REQ-022 HOLD with out_ready=0 and a slot with sin=1: overrun SHALL be set; the start bit SHALL be dropped; out and out_valid SHALL be unaffected.
REQ-023 HOLD with out_ready=1 and a start slot in the same cycle: the handshake SHALL complete, the start bit SHALL be ignored, and overrun SHALL not be set.
REQ-024 ovr_clr=1 SHALL clear overrun on the next edge; if a set condition occurs in the same cycle, set SHALL win.
REQ-025 Cycles with sin_en=0 SHALL not advance the state, counter or shift register, in any state.

Reset
REQ-026 res=0 SHALL immediately force: state IDLE, counter 0, shift register 0, out=4'b0000, out_valid=0, par_err=0, overrun=0.
REQ-027 Reset mid-frame SHALL discard all partial data; the first slot with sin=1 after res=1 SHALL be treated as a start bit.

Structure
REQ-028 A shared package SHALL hold the state encoding (2-bit, IDLE=0, COLLECT=1, PARITY=2, HOLD=3) and the constant WORD_W=4.
REQ-029 One sub-module, shift_reg4, SHALL implement the 4-bit shift register with shift-enable and a direction parameter; the FSM, counter, parity and flags SHALL stay in serial_deser4.

Verification
REQ-030 Nominal frame (PARITY_EN=1, MSB_FIRST=1): slots 1(start),1,0,1,1,1(parity) -> out=4'b1011 and out_valid=1 the cycle after the parity slot; par_err=0.
REQ-031 Bad parity: slots 1,1,0,1,1,0 -> par_err high exactly 1 cycle; out_valid stays 0; out keeps its prior value; next good frame is accepted.
REQ-032 Backpressure: hold out_ready=0 after a valid word, then send start slot sin=1 -> overrun=1 and out=4'b1011 unchanged; out_ready=1 -> out_valid=0 next cycle; ovr_clr=1 -> overrun=0.
REQ-033 LSB-first, no parity (MSB_FIRST=0, PARITY_EN=0): slots 1,1,0,0,0 -> out=4'b0001 and out_valid=1 the cycle after the 4th data slot.
REQ-034 Gapped strobe plus reset: nominal frame with 3 idle cycles (sin_en=0, sin toggling) between slots -> same result as REQ-030; res=0 after 2 data bits -> all outputs 0, state IDLE; following frame received correctly.

Source files
------------

// File: rtl/serial_deser4_pkg.sv
// Shared definitions for the serial_deser4 deserializer: word width, FSM state encoding
// and the even-parity helper.
package serial_deser4_pkg;

    localparam int WORD_W = 4;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // True when data bits plus the parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [WORD_W-1:0] data, input logic pbit);
        return ~(^data ^ pbit);
    endfunction

endpackage

// File: rtl/serial_deser4_if.sv
// Serial input, parallel word handshake and status flags of serial_deser4.
// The slave modport is the deserializer side; master is the driver/consumer side.
interface serial_deser4_if;
    import serial_deser4_pkg::*;

    logic              sin;
    logic              sin_en;
    logic [WORD_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic              par_err;
    logic              overrun;
    logic              ovr_clr;

    modport master (
        output sin, sin_en, out_ready, ovr_clr,
        input  out, out_valid, par_err, overrun
    );

    modport slave (
        input  sin, sin_en, out_ready, ovr_clr,
        output out, out_valid, par_err, overrun
    );

endinterface

// File: rtl/serial_deser4_shift_reg4.sv
// 4-bit shift register with shift enable; MSB_FIRST selects shift-left (enter at bit 0)
// or shift-right (enter at bit 3). data_nxt exposes the value the next edge will load.
module shift_reg4
    import serial_deser4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              shift_en,
    input  logic              din,
    output logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] data_nxt
);

    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            if (MSB_FIRST) begin
                data_d = {data_q[WORD_W-2:0], din};
            end else begin
                data_d = {din, data_q[WORD_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data     = data_q;
    assign data_nxt = data_d;

endmodule

// File: rtl/serial_deser4.sv
// Serial-to-4-bit deserializer: start bit, four data bits, optional even parity bit,
// then a valid/ready hold with a sticky overrun flag for starts arriving while a word is pending.
module serial_deser4
    import serial_deser4_pkg::*;
#(
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           res,
    serial_deser4_if.slave bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              par_err_q, par_err_d;
    logic              overrun_q, overrun_d;

    logic              shift_en;
    logic              ovr_set;
    logic              slot;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;

    assign slot = bus.sin_en;

    shift_reg4 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .res      (res),
        .shift_en (shift_en),
        .din      (bus.sin),
        .data     (shreg),
        .data_nxt (shreg_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        par_err_d = 1'b0;
        shift_en  = 1'b0;
        ovr_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (slot && bus.sin) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                if (slot) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WORD_W - 1)) begin
                        cnt_d = '0;
                        if (PARITY_EN) begin
                            state_d = PARITY;
                        end else begin
                            // Without parity the word is complete on this edge, so load
                            // the value the shifter is about to take.
                            out_d   = shreg_nxt;
                            state_d = HOLD;
                        end
                    end
                end
            end
            PARITY: begin
                if (slot) begin
                    if (even_parity_ok(shreg, bus.sin)) begin
                        out_d   = shreg;
                        state_d = HOLD;
                    end else begin
                        par_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                // A completed handshake takes priority and swallows a coincident start.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else if (slot && bus.sin) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            par_err_q   <= par_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.par_err   = par_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_serial_deser4.sv
// Directed bench for serial_deser4: dut_a uses parity + MSB-first, dut_b no parity + LSB-first.
module tb_serial_deser4;
    import serial_deser4_pkg::*;

    logic clk = 1'b0;
    logic res;

    serial_deser4_if if_a ();
    serial_deser4_if if_b ();

    serial_deser4 #(.PARITY_EN(1'b1), .MSB_FIRST(1'b1)) dut_a (
        .clk (clk),
        .res (res),
        .bus (if_a.slave)
    );

    serial_deser4 #(.PARITY_EN(1'b0), .MSB_FIRST(1'b0)) dut_b (
        .clk (clk),
        .res (res),
        .bus (if_b.slave)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap idle cycles with sin toggling and sin_en low, then one bit slot.
    task automatic slot_a(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            if_a.sin_en = 1'b0;
            if_a.sin    = ~if_a.sin;
            tick();
        end
        if_a.sin_en = 1'b1;
        if_a.sin    = b;
        tick();
        if_a.sin_en = 1'b0;
        if_a.sin    = 1'b0;
    endtask

    task automatic slot_b(input logic b);
        if_b.sin_en = 1'b1;
        if_b.sin    = b;
        tick();
        if_b.sin_en = 1'b0;
        if_b.sin    = 1'b0;
    endtask

    task automatic frame_a(input logic [3:0] d, input logic p, input int gap);
        slot_a(1'b1, gap);
        for (int i = 3; i >= 0; i--) slot_a(d[i], gap);
        slot_a(p, gap);
    endtask

    task automatic handshake_a();
        if_a.out_ready = 1'b1;
        tick();
        if_a.out_ready = 1'b0;
    endtask

    initial begin
        res = 1'b0;
        if_a.sin = 1'b0; if_a.sin_en = 1'b0; if_a.out_ready = 1'b0; if_a.ovr_clr = 1'b0;
        if_b.sin = 1'b0; if_b.sin_en = 1'b0; if_b.out_ready = 1'b0; if_b.ovr_clr = 1'b0;
        tick();
        tick();
        check("rst_out",       32'(if_a.out),       32'h0);
        check("rst_valid",     32'(if_a.out_valid), 32'h0);
        check("rst_par_err",   32'(if_a.par_err),   32'h0);
        check("rst_overrun",   32'(if_a.overrun),   32'h0);
        check("rst_b_out",     32'(if_b.out),       32'h0);
        res = 1'b1;
        tick();

        // Nominal frame: data 1011, parity 1.
        slot_a(1'b1, 0);
        slot_a(1'b1, 0); slot_a(1'b0, 0); slot_a(1'b1, 0); slot_a(1'b1, 0);
        check("nom_valid_pre", 32'(if_a.out_valid), 32'h0);
        slot_a(1'b1, 0);
        check("nom_out",       32'(if_a.out),       32'hb);
        check("nom_valid",     32'(if_a.out_valid), 32'h1);
        check("nom_par_err",   32'(if_a.par_err),   32'h0);

        // Backpressure: gated toggles are ignored, a real start sets overrun.
        slot_a(1'b0, 2);
        check("bp_valid_hold", 32'(if_a.out_valid), 32'h1);
        check("bp_no_ovr",     32'(if_a.overrun),   32'h0);
        slot_a(1'b1, 0);
        check("bp_overrun",    32'(if_a.overrun),   32'h1);
        check("bp_out",        32'(if_a.out),       32'hb);
        check("bp_valid",      32'(if_a.out_valid), 32'h1);
        if_a.ovr_clr = 1'b1;
        slot_a(1'b1, 0);
        if_a.ovr_clr = 1'b0;
        check("bp_set_wins",   32'(if_a.overrun),   32'h1);
        handshake_a();
        check("bp_hs_valid",   32'(if_a.out_valid), 32'h0);
        check("bp_hs_out",     32'(if_a.out),       32'hb);
        if_a.ovr_clr = 1'b1;
        tick();
        if_a.ovr_clr = 1'b0;
        check("bp_ovr_clr",    32'(if_a.overrun),   32'h0);

        // Handshake coincident with a start slot: start ignored, no overrun.
        frame_a(4'b0110, 1'b0, 0);
        check("co_out",        32'(if_a.out),       32'h6);
        if_a.out_ready = 1'b1; if_a.sin_en = 1'b1; if_a.sin = 1'b1;
        tick();
        if_a.out_ready = 1'b0; if_a.sin_en = 1'b0; if_a.sin = 1'b0;
        check("co_valid",      32'(if_a.out_valid), 32'h0);
        check("co_overrun",    32'(if_a.overrun),   32'h0);
        frame_a(4'b0011, 1'b0, 0);
        check("co_next_out",   32'(if_a.out),       32'h3);
        check("co_next_valid", 32'(if_a.out_valid), 32'h1);
        handshake_a();

        // Bad parity: one-cycle pulse, word discarded, next frame accepted.
        frame_a(4'b1011, 1'b0, 0);
        check("bad_par_err",   32'(if_a.par_err),   32'h1);
        check("bad_valid",     32'(if_a.out_valid), 32'h0);
        check("bad_out",       32'(if_a.out),       32'h3);
        tick();
        check("bad_pulse_end", 32'(if_a.par_err),   32'h0);
        frame_a(4'b0110, 1'b0, 0);
        check("bad_next_out",  32'(if_a.out),       32'h6);
        check("bad_next_vld",  32'(if_a.out_valid), 32'h1);
        handshake_a();

        // Gapped strobe: 3 gated cycles with sin toggling before each slot.
        frame_a(4'b1011, 1'b1, 3);
        check("gap_out",       32'(if_a.out),       32'hb);
        check("gap_valid",     32'(if_a.out_valid), 32'h1);
        handshake_a();

        // Reset after two data bits discards the partial frame.
        slot_a(1'b1, 0); slot_a(1'b1, 0); slot_a(1'b0, 0);
        res = 1'b0;
        #1;
        check("mid_rst_out",   32'(if_a.out),       32'h0);
        check("mid_rst_valid", 32'(if_a.out_valid), 32'h0);
        check("mid_rst_ovr",   32'(if_a.overrun),   32'h0);
        tick();
        res = 1'b1;
        frame_a(4'b0111, 1'b1, 0);
        check("post_rst_out",  32'(if_a.out),       32'h7);
        check("post_rst_vld",  32'(if_a.out_valid), 32'h1);
        handshake_a();

        // LSB-first, no parity: first data bit lands in out[0].
        slot_b(1'b1);
        slot_b(1'b1); slot_b(1'b0); slot_b(1'b0);
        check("lsb_valid_pre", 32'(if_b.out_valid), 32'h0);
        slot_b(1'b0);
        check("lsb_out",       32'(if_b.out),       32'h1);
        check("lsb_valid",     32'(if_b.out_valid), 32'h1);
        if_b.out_ready = 1'b1;
        tick();
        if_b.out_ready = 1'b0;
        check("lsb_hs_valid",  32'(if_b.out_valid), 32'h0);
        slot_b(1'b1);
        slot_b(1'b1); slot_b(1'b1); slot_b(1'b0); slot_b(1'b0);
        check("lsb_out2",      32'(if_b.out),       32'h3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
